// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: serially loads a pattern, runs capture cycles with SE low,
// then unloads the captured response from the chain's last cell.
//
// state  | meaning
// IDLE   | waiting for start_i; SE and SI held low
// LOAD   | shifting the latched pattern into the chain, MSB first
// CAPT   | SE low for CAPTURE_CYC edges so the cells capture functional data
// UNLOAD | shifting the response out via so_i into resp
module scan_chain_ctrl #(
  parameter int CHAIN_LEN   = 16,
  parameter int CAPTURE_CYC = 1
) (
  input  logic                 ck_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CHAIN_LEN-1:0] pat_in_i,
  input  logic                 so_i,
  output logic                 se_o,
  output logic                 si_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CHAIN_LEN-1:0] resp_o
);

  localparam int N     = CHAIN_LEN;
  localparam int C     = CAPTURE_CYC;
  localparam int CNT_W = $clog2(N + C + 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CAPT_LAST  = CNT_W'(C - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CAPT, UNLOAD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic [N-1:0]     resp_q, resp_d;
  logic             se_q, se_d;
  logic             si_q, si_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge ck_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      resp_q   <= '0;
      se_q     <= 1'b0;
      si_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      resp_q   <= resp_d;
      se_q     <= se_d;
      si_q     <= si_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    resp_d   = resp_q;
    se_d     = se_q;
    si_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        se_d = 1'b0;
        if (start_i) begin
          state_d  = LOAD;
          // MSB goes out now; the shadow keeps the rest left-aligned so its MSB is always next
          shadow_d = pat_in_i << 1;
          si_d     = pat_in_i[N-1];
          se_d     = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      LOAD: begin
        if (cnt_q == SHIFT_LAST) begin
          state_d = CAPT;
          se_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          si_d     = shadow_q[N-1];
          shadow_d = shadow_q << 1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      CAPT: begin
        if (cnt_q == CAPT_LAST) begin
          state_d = UNLOAD;
          se_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UNLOAD: begin
        // so_i presents cell N-1 first, so the k-th sample lands in resp[N-1-k]
        for (int k = 0; k < N; k++) begin
          if (cnt_q == CNT_W'(N - 1 - k)) resp_d[k] = so_i;
        end
        if (cnt_q == SHIFT_LAST) begin
          state_d = IDLE;
          se_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign se_o   = se_q;
  assign si_o   = si_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign resp_o = resp_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Self-checking bench for scan_chain_ctrl: two instances (N=16,C=1 and N=1,C=3), each
// driving a behavioural scan chain whose capture function is Q ^ mask.
module tb_scan_chain_ctrl;

  typedef struct {
    logic [15:0] pat;
    logic [15:0] mask;
    logic [15:0] exp;
  } vec_t;

  logic        ck = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [15:0] pat_a, mask_a;
  logic        pat_b, mask_b;
  logic        so_a, so_b;
  logic        se_a, si_a, busy_a, done_a;
  logic        se_b, si_b, busy_b, done_b;
  logic [15:0] resp_a;
  logic        resp_b;
  logic [15:0] chain_a = '0;
  logic        chain_b = 1'b0;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_edge;
  logic [15:0] resp_seen;
  vec_t        vt[6];

  scan_chain_ctrl #(.CHAIN_LEN(16), .CAPTURE_CYC(1)) u_dut_a (
    .ck_i(ck), .rst_i(rst), .start_i(start_a), .pat_in_i(pat_a), .so_i(so_a),
    .se_o(se_a), .si_o(si_a), .busy_o(busy_a), .done_o(done_a), .resp_o(resp_a)
  );

  scan_chain_ctrl #(.CHAIN_LEN(1), .CAPTURE_CYC(3)) u_dut_b (
    .ck_i(ck), .rst_i(rst), .start_i(start_b), .pat_in_i(pat_b), .so_i(so_b),
    .se_o(se_b), .si_o(si_b), .busy_o(busy_b), .done_o(done_b), .resp_o(resp_b)
  );

  always #5 ck = ~ck;

  // Chain models: shift toward the last cell when SE is high, otherwise capture Q ^ mask
  always @(posedge ck) begin
    if (se_a) chain_a <= {chain_a[14:0], si_a};
    else      chain_a <= chain_a ^ mask_a;
    if (se_b) chain_b <= si_b;
    else      chain_b <= chain_b ^ mask_b;
  end
  assign so_a = chain_a[15];
  assign so_b = chain_b;

  function automatic logic [15:0] ref_resp(input logic [15:0] pat, input logic [15:0] mask,
                                           input int caps);
    logic [15:0] v;
    v = pat;
    for (int i = 0; i < caps; i++) v = v ^ mask;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_txn(input bit b, input logic [15:0] pat, input logic [15:0] mask,
                        input logic [15:0] exp, input string nm);
    int          n, c, d_edge, ndone, se_bad, si_bad;
    logic        exp_se, exp_si, cur_se, cur_si, cur_done, busy_at_done;
    logic [15:0] sh, resp_at_done;
    n = b ? 1 : 16;
    c = b ? 3 : 1;
    @(negedge ck);
    if (b) begin pat_b = pat[0]; mask_b = mask[0]; start_b = 1'b1; end
    else   begin pat_a = pat;    mask_a = mask;    start_a = 1'b1; end
    @(posedge ck);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    pat_a   = ~pat_a;
    pat_b   = ~pat_b;
    d_edge = -1; ndone = 0; se_bad = 0; si_bad = 0;
    busy_at_done = 1'b1; resp_at_done = '0;
    for (int e = 1; e <= 2*n + c + 3; e++) begin
      @(negedge ck);
      cur_se   = b ? se_b : se_a;
      cur_si   = b ? si_b : si_a;
      cur_done = b ? done_b : done_a;
      exp_se = (e <= n) || (e > n + c && e <= 2*n + c);
      exp_si = 1'b0;
      if (e <= n) begin
        sh     = pat >> (n - e);
        exp_si = sh[0];
      end
      if (e <= 2*n + c + 1) begin
        if (cur_se !== exp_se) se_bad++;
        if (cur_si !== exp_si) si_bad++;
      end
      if (cur_done === 1'b1) begin
        ndone++;
        if (d_edge < 0) begin
          d_edge       = e - 1;
          resp_at_done = b ? {15'b0, resp_b} : resp_a;
          busy_at_done = b ? busy_b : busy_a;
        end
      end
    end
    chk({nm, ":se_window_errs"}, se_bad, 0);
    chk({nm, ":si_seq_errs"}, si_bad, 0);
    chk({nm, ":done_edge"}, d_edge, 2*n + c);
    chk({nm, ":done_count"}, ndone, 1);
    chk({nm, ":busy_at_done"}, int'(busy_at_done), 0);
    chk({nm, ":resp"}, int'(resp_at_done), int'(exp));
  endtask

  task automatic mid_reset(input int at_edge, input int dly, input string nm);
    int ndone;
    @(negedge ck);
    pat_a   = 16'($urandom);
    mask_a  = 16'($urandom);
    start_a = 1'b1;
    @(posedge ck);
    #1 start_a = 1'b0;
    for (int e = 1; e <= at_edge; e++) @(posedge ck);
    #(dly);
    rst = 1'b1;
    #1;
    chk({nm, ":se"},   int'(se_a),   0);
    chk({nm, ":si"},   int'(si_a),   0);
    chk({nm, ":busy"}, int'(busy_a), 0);
    chk({nm, ":done"}, int'(done_a), 0);
    chk({nm, ":resp"}, int'(resp_a), 0);
    @(negedge ck);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ck);
      if (done_a === 1'b1) ndone++;
    end
    chk({nm, ":no_done_after_abort"}, ndone, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] p, m;
    vt[0] = '{16'hA5C3, 16'hFFFF, 16'h5A3C};
    vt[1] = '{16'h8001, 16'h0000, 16'h8001};
    vt[2] = '{16'h1234, 16'h00FF, 16'h12CB};
    vt[3] = '{16'hFFFF, 16'hFFFF, 16'h0000};
    vt[4] = '{16'h0000, 16'h0F0F, 16'h0F0F};
    vt[5] = '{16'h7E81, 16'h8000, 16'hFE81};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    pat_a = '0; mask_a = '0; pat_b = 1'b0; mask_b = 1'b0;
    #23;
    chk("reset:se_a", int'(se_a), 0);
    chk("reset:si_a", int'(si_a), 0);
    chk("reset:busy_a", int'(busy_a), 0);
    chk("reset:done_a", int'(done_a), 0);
    chk("reset:resp_a", int'(resp_a), 0);
    chk("reset:busy_b", int'(busy_b), 0);
    @(negedge ck);
    rst = 1'b0;

    // START held high across a whole transaction with PAT_IN disturbed mid-load
    @(negedge ck);
    pat_a = 16'hA5C3; mask_a = 16'hFFFF; start_a = 1'b1;
    @(posedge ck);
    done_edge = -1;
    for (int e = 1; e <= 60 && done_edge < 0; e++) begin
      @(negedge ck);
      if (e == 6) pat_a = 16'hFFFF;
      if (done_a === 1'b1) begin done_edge = e - 1; resp_seen = resp_a; end
    end
    chk("hold:done_edge", done_edge, 33);
    chk("hold:resp", int'(resp_seen), 16'h5A3C);
    @(posedge ck);
    #1;
    chk("hold:reaccept_busy", int'(busy_a), 1);
    chk("hold:reaccept_se", int'(se_a), 1);
    chk("hold:done_cleared", int'(done_a), 0);
    start_a = 1'b0;
    done_edge = -1;
    for (int e = 1; e <= 60 && done_edge < 0; e++) begin
      @(negedge ck);
      if (done_a === 1'b1) begin done_edge = e - 1; resp_seen = resp_a; end
    end
    chk("hold2:done_edge", done_edge, 33);
    chk("hold2:resp", int'(resp_seen), 16'h0000);

    for (int i = 0; i < 6; i++) do_txn(1'b0, vt[i].pat, vt[i].mask, vt[i].exp, $sformatf("vec%0d", i));

    mid_reset(10, 3, "rst_midcycle");

    for (int i = 0; i < 20; i++) begin
      p = 16'($urandom);
      m = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      do_txn(1'b0, p, m, ref_resp(p, m, 1), $sformatf("rand_a%0d", i));
    end

    do_txn(1'b0, 16'hA5C3, 16'hFFFF, 16'h5A3C, "pre_abort");
    mid_reset(20, 1, "rst_edge20");
    do_txn(1'b0, 16'h8001, 16'h0000, 16'h8001, "post_abort");

    do_txn(1'b1, 16'h0001, 16'h0001, 16'h0000, "n1_inv");
    for (int i = 0; i < 6; i++) begin
      p = 16'($urandom_range(0, 1));
      m = 16'($urandom_range(0, 1));
      do_txn(1'b1, p, m, ref_resp(p, m, 3) & 16'h0001, $sformatf("rand_b%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
